// File: rtl/regfile_wb_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_if
// Description : rd writeback and operand read bundle between the core and
//               regfile_wb. Carries the ALU/LSU write requests, the two read
//               ports and the writeback stall.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_wb_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            alu_rd_we_i;
    logic [AW-1:0]   alu_rd_waddr_i;
    logic [XLEN-1:0] alu_rd_wdata_i;
    logic            lsu_rd_we_i;
    logic [AW-1:0]   lsu_rd_waddr_i;
    logic [XLEN-1:0] lsu_rd_wdata_i;
    logic [AW-1:0]   rs1_raddr_i;
    logic [AW-1:0]   rs2_raddr_i;
    logic [XLEN-1:0] rs1_rdata_o;
    logic [XLEN-1:0] rs2_rdata_o;
    logic            wb_stall_o;

    modport master (
        output alu_rd_we_i, alu_rd_waddr_i, alu_rd_wdata_i,
        output lsu_rd_we_i, lsu_rd_waddr_i, lsu_rd_wdata_i,
        output rs1_raddr_i, rs2_raddr_i,
        input  rs1_rdata_o, rs2_rdata_o, wb_stall_o
    );

    modport slave (
        input  alu_rd_we_i, alu_rd_waddr_i, alu_rd_wdata_i,
        input  lsu_rd_we_i, lsu_rd_waddr_i, lsu_rd_wdata_i,
        input  rs1_raddr_i, rs2_raddr_i,
        output rs1_rdata_o, rs2_rdata_o, wb_stall_o
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb
// Description : Integer register file with ALU/LSU writeback arbitration,
//               one deferred write slot and two combinational read ports.
//               Optional macro REGFILE_WB_BYPASS_EN adds same-cycle forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb #(
    parameter int NUM_REGS = 32,
    parameter int XLEN     = 32
) (
    input  wire logic   clk_i,
    input  wire logic   rst_i,
    regfile_wb_if.slave rf
);
    localparam int AW = $clog2(NUM_REGS);

    logic [XLEN-1:0] r_regs [NUM_REGS];
    logic            r_pend_valid;
    logic [AW-1:0]   r_pend_addr;
    logic [XLEN-1:0] r_pend_data;

    logic            w_alu_v;
    logic            w_lsu_v;
    logic            w_cmt_en;
    logic [AW-1:0]   w_cmt_addr;
    logic [XLEN-1:0] w_cmt_data;
    logic            w_pend_load;

    assign w_alu_v = rf.alu_rd_we_i && (rf.alu_rd_waddr_i != '0);
    assign w_lsu_v = rf.lsu_rd_we_i && (rf.lsu_rd_waddr_i != '0);

    // Pending slot always wins; new requests during a stall are ignored.
    always_comb begin
        w_cmt_en    = 1'b0;
        w_cmt_addr  = '0;
        w_cmt_data  = '0;
        w_pend_load = 1'b0;
        if (r_pend_valid) begin
            w_cmt_en   = 1'b1;
            w_cmt_addr = r_pend_addr;
            w_cmt_data = r_pend_data;
        end else if (w_alu_v) begin
            w_cmt_en    = 1'b1;
            w_cmt_addr  = rf.alu_rd_waddr_i;
            w_cmt_data  = rf.alu_rd_wdata_i;
            // Same-address LSU write is older than the ALU one, so it is dropped.
            w_pend_load = w_lsu_v && (rf.lsu_rd_waddr_i != rf.alu_rd_waddr_i);
        end else if (w_lsu_v) begin
            w_cmt_en   = 1'b1;
            w_cmt_addr = rf.lsu_rd_waddr_i;
            w_cmt_data = rf.lsu_rd_wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
        end else begin
            if (w_cmt_en) begin
                r_regs[w_cmt_addr] <= w_cmt_data;
            end
            r_pend_valid <= w_pend_load;
            if (w_pend_load) begin
                r_pend_addr <= rf.lsu_rd_waddr_i;
                r_pend_data <= rf.lsu_rd_wdata_i;
            end
        end
    end

    logic [AW-1:0]   w_raddr [2];
    logic [XLEN-1:0] w_rdata [2];

    assign w_raddr[0]     = rf.rs1_raddr_i;
    assign w_raddr[1]     = rf.rs2_raddr_i;
    assign rf.rs1_rdata_o = w_rdata[0];
    assign rf.rs2_rdata_o = w_rdata[1];
    assign rf.wb_stall_o  = r_pend_valid;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_rd_port
            always_comb begin
                w_rdata[p] = '0;
                if (rst_i || (w_raddr[p] == '0)) begin
                    w_rdata[p] = '0;
`ifdef REGFILE_WB_BYPASS_EN
                end else if (w_cmt_en && (w_raddr[p] == w_cmt_addr)) begin
                    w_rdata[p] = w_cmt_data;
`endif
                end else if (r_pend_valid && (w_raddr[p] == r_pend_addr)) begin
                    // Array still holds the stale value until the slot drains.
                    w_rdata[p] = r_pend_data;
                end else begin
                    w_rdata[p] = r_regs[w_raddr[p]];
                end
            end
        end
    endgenerate
endmodule
`default_nettype wire

// File: tb/tb_regfile_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb
// Description : Directed self-checking bench for regfile_wb.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb;
    localparam int c_xlen = 32;
    localparam int c_aw   = 5;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    regfile_wb_if #(.XLEN(c_xlen), .AW(c_aw)) rf ();

    regfile_wb #(.NUM_REGS(32), .XLEN(c_xlen)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .rf    (rf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf.alu_rd_we_i    = 1'b0;
        rf.alu_rd_waddr_i = '0;
        rf.alu_rd_wdata_i = '0;
        rf.lsu_rd_we_i    = 1'b0;
        rf.lsu_rd_waddr_i = '0;
        rf.lsu_rd_wdata_i = '0;
    endtask

    task automatic drive(input logic aw, input logic [4:0] aa, input logic [31:0] ad,
                         input logic lw, input logic [4:0] la, input logic [31:0] ld);
        rf.alu_rd_we_i    = aw;
        rf.alu_rd_waddr_i = aa;
        rf.alu_rd_wdata_i = ad;
        rf.lsu_rd_we_i    = lw;
        rf.lsu_rd_waddr_i = la;
        rf.lsu_rd_wdata_i = ld;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        rf.rs1_raddr_i = a1;
        rf.rs2_raddr_i = a2;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        rf.rs1_raddr_i = 5'd1;
        rf.rs2_raddr_i = 5'd2;
        rst = 1'b1;
        tick();
        tick();
        check_eq("rst_stall", {31'd0, rf.wb_stall_o}, 32'd0);
        check_eq("rst_rs1", rf.rs1_rdata_o, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            rd(i[4:0], 5'(31 - i));
            check_eq("init_rs1", rf.rs1_rdata_o, 32'd0);
            check_eq("init_rs2", rf.rs2_rdata_o, 32'd0);
        end
        check_eq("init_stall", {31'd0, rf.wb_stall_o}, 32'd0);

        // Single ALU write and write-to-read latency
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        rd(5'd5, 5'd0);
`ifdef REGFILE_WB_BYPASS_EN
        check_eq("same_cyc_x5", rf.rs1_rdata_o, 32'hDEADBEEF);
`else
        check_eq("same_cyc_x5", rf.rs1_rdata_o, 32'd0);
`endif
        tick();
        idle();
        rd(5'd5, 5'd0);
        check_eq("x5", rf.rs1_rdata_o, 32'hDEADBEEF);
        check_eq("x0_rs2", rf.rs2_rdata_o, 32'd0);
        check_eq("x5_stall", {31'd0, rf.wb_stall_o}, 32'd0);
        rd(5'd5, 5'd5);
        check_eq("x5_both", rf.rs2_rdata_o, 32'hDEADBEEF);

        // Collision on different addresses: LSU deferred one cycle
        drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        tick();
        // Illegal request during stall must be ignored
        drive(1'b1, 5'd10, 32'h77, 1'b1, 5'd11, 32'h88);
        rd(5'd4, 5'd3);
        check_eq("coll_stall", {31'd0, rf.wb_stall_o}, 32'd1);
        check_eq("coll_pend_x4", rf.rs1_rdata_o, 32'h22);
        check_eq("coll_x3", rf.rs2_rdata_o, 32'h11);
        tick();
        idle();
        rd(5'd3, 5'd4);
        check_eq("drain_stall", {31'd0, rf.wb_stall_o}, 32'd0);
        check_eq("drain_x3", rf.rs1_rdata_o, 32'h11);
        check_eq("drain_x4", rf.rs2_rdata_o, 32'h22);
        rd(5'd10, 5'd11);
        check_eq("ignored_x10", rf.rs1_rdata_o, 32'd0);
        check_eq("ignored_x11", rf.rs2_rdata_o, 32'd0);

        // Same-address collision: ALU wins, no stall
        drive(1'b1, 5'd7, 32'hAAAA, 1'b1, 5'd7, 32'h5555);
        tick();
        idle();
        rd(5'd7, 5'd7);
        check_eq("same_addr_stall", {31'd0, rf.wb_stall_o}, 32'd0);
        check_eq("same_addr_x7", rf.rs1_rdata_o, 32'hAAAA);
        tick();
        check_eq("same_addr_x7_later", rf.rs2_rdata_o, 32'hAAAA);

        // x0 writes from both sources are dropped
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'h1234);
        tick();
        idle();
        rd(5'd0, 5'd0);
        check_eq("x0_stall", {31'd0, rf.wb_stall_o}, 32'd0);
        check_eq("x0_read", rf.rs1_rdata_o, 32'd0);

        // ALU to x0 with LSU valid behaves as a lone LSU write
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd12, 32'hC0DE);
        tick();
        idle();
        rd(5'd12, 5'd0);
        check_eq("x0_alu_stall", {31'd0, rf.wb_stall_o}, 32'd0);
        check_eq("x0_alu_x12", rf.rs1_rdata_o, 32'hC0DE);

        // Reset while a pending entry is held
        drive(1'b1, 5'd8, 32'h88, 1'b1, 5'd9, 32'h99);
        tick();
        idle();
        rd(5'd9, 5'd8);
        check_eq("pre_rst_stall", {31'd0, rf.wb_stall_o}, 32'd1);
        check_eq("pre_rst_x9", rf.rs1_rdata_o, 32'h99);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd(5'd9, 5'd8);
        check_eq("post_rst_stall", {31'd0, rf.wb_stall_o}, 32'd0);
        check_eq("post_rst_x9", rf.rs1_rdata_o, 32'd0);
        check_eq("post_rst_x8", rf.rs2_rdata_o, 32'd0);
        tick();
        rd(5'd9, 5'd5);
        check_eq("post_rst_x9_later", rf.rs1_rdata_o, 32'd0);
        check_eq("post_rst_x5", rf.rs2_rdata_o, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
